// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-decode stage: format tags,
// RV32I/RV64I opcodes and the buffered entry layout.
package imm_pkg;

  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Fields are sized for the widest datapath; narrower stages zero-fill the top.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    fmt_e                fmt;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] target;
  } dec_entry_t;

  function automatic logic has_target(input fmt_e f);
    return !(f == FMT_NONE || f == FMT_Z);
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate extraction: raw instruction to XLEN immediate and
// format tag.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o
);

  logic [6:0]         opc;
  logic [2:0]         funct3;
  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic signed [12:0] imm_b13;
  logic signed [20:0] imm_j21;
  logic signed [31:0] imm_u32;

  assign opc     = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign imm_i12 = instr_i[31:20];
  assign imm_s12 = {instr_i[31:25], instr_i[11:7]};
  assign imm_b13 = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j21 = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_u32 = {instr_i[31:12], 12'b0};

  always_comb begin
    imm_o = '0;
    fmt_o = FMT_NONE;
    case (opc)
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm_o = XLEN'(imm_i12);
        fmt_o = FMT_I;
      end
      OP_SYSTEM: begin
        // CSR-immediate forms carry an unsigned 5-bit zimm in the rs1 field.
        if (funct3[2]) begin
          imm_o = XLEN'(instr_i[19:15]);
          fmt_o = FMT_Z;
        end else if (funct3 != 3'b000) begin
          imm_o = XLEN'(imm_i12);
          fmt_o = FMT_I;
        end
      end
      OP_STORE: begin
        imm_o = XLEN'(imm_s12);
        fmt_o = FMT_S;
      end
      OP_BRANCH: begin
        imm_o = XLEN'(imm_b13);
        fmt_o = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm_o = XLEN'(imm_u32);
        fmt_o = FMT_U;
      end
      OP_JAL: begin
        imm_o = XLEN'(imm_j21);
        fmt_o = FMT_J;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with PC-relative target precompute and an
// optional two-entry skid buffer on the valid/ready interface.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] tgt_sum;
  dec_entry_t      new_e;
  dec_entry_t      m_q, m_d, k_q, k_d;
  logic            m_vld_q, m_vld_d, k_vld_q, k_vld_d;
  logic            rdy_q;
  logic            acc, m_ret;
  logic            unused_hi;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr_i (in_instr),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt)
  );

  assign tgt_sum = in_pc + dec_imm;

  always_comb begin
    new_e.imm    = XLEN_MAX'(dec_imm);
    new_e.fmt    = dec_fmt;
    new_e.pc     = XLEN_MAX'(in_pc);
    new_e.target = has_target(dec_fmt) ? XLEN_MAX'(tgt_sum) : '0;
  end

  assign in_ready = SKID_EN ? rdy_q : (rdy_q && (out_ready || !m_vld_q));
  assign acc      = in_valid && in_ready && !flush;
  assign m_ret    = m_vld_q && out_ready;

  always_comb begin
    m_d     = m_q;
    k_d     = k_q;
    m_vld_d = m_vld_q;
    k_vld_d = k_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end else if (!m_vld_q || m_ret) begin
      // K never holds an entry while in_ready is high, so a waiting K entry
      // and a new accept cannot collide here.
      if (k_vld_q) begin
        m_d     = k_q;
        m_vld_d = 1'b1;
        k_vld_d = 1'b0;
      end else if (acc) begin
        m_d     = new_e;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (acc && SKID_EN) begin
      k_d     = new_e;
      k_vld_d = 1'b1;
    end
  end

  // Main register and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      m_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      m_q     <= m_d;
      m_vld_q <= m_vld_d;
      k_vld_q <= k_vld_d;
      rdy_q   <= !k_vld_d;
    end
  end

  // Skid payload: only meaningful while k_vld_q is set
  always_ff @(posedge clk) begin
    k_q <= k_d;
  end

  assign out_valid  = m_vld_q;
  assign out_imm    = m_q.imm[XLEN-1:0];
  assign out_fmt    = m_q.fmt;
  assign out_pc     = m_q.pc[XLEN-1:0];
  assign out_target = m_q.target[XLEN-1:0];
  assign unused_hi  = ^{m_q.imm, m_q.pc, m_q.target};

endmodule
